// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper: state encoding, counter width
// and golden tables of the lab functions.
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    // Wide enough for the largest legal SETTLE-1 (14).
    localparam int unsigned SETTLE_CNT_W = 4;

    // out = d & (~a | ~b | c), bit i is the result for {a,b,c,d} == i.
    localparam logic [15:0] GOLDEN_DEFAULT = 16'h8AAA;

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable down-counter; expired_c is high while the count sits at zero.
module tt_settle_cnt
    import tt_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [SETTLE_CNT_W-1:0] load_val,
    input  logic                    en,
    output logic                    expired_c
);

    logic [SETTLE_CNT_W-1:0] cnt_q;
    logic [SETTLE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - SETTLE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep.sv
// Exhaustive truth-table sweeper: drives every input vector, samples the function
// result after a settle delay, and checks the assembled table against GOLDEN.
module tt_sweep
    import tt_pkg::*;
#(
    parameter int unsigned           N_IN   = 4,
    parameter int unsigned           SETTLE = 1,
    parameter logic [2**N_IN-1:0]    GOLDEN = GOLDEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        ones_cnt,
    output logic                 pass,
    output logic                 mism_valid,
    output logic [N_IN-1:0]      mism_idx
);

    localparam int unsigned TBL_W = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TBL_W - 1);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

    tt_state_e          state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TBL_W-1:0]   table_q, table_d;
    logic [N_IN:0]      ones_q, ones_d;
    logic               pass_q, pass_d;
    logic               mv_q, mv_d;
    logic [N_IN-1:0]    mi_q, mi_d;
    logic               cnt_load;
    logic               cnt_en;
    logic               settled_c;

    tt_settle_cnt u_settle (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_val  (SETTLE_LOAD),
        .en        (cnt_en),
        .expired_c (settled_c)
    );

    // Next-state and result-register update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        table_d  = table_q;
        ones_d   = ones_q;
        pass_d   = pass_q;
        mv_d     = mv_q;
        mi_d     = mi_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    table_d  = '0;
                    ones_d   = '0;
                    pass_d   = 1'b0;
                    mv_d     = 1'b0;
                    mi_d     = '0;
                    cnt_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (settled_c) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                table_d[idx_q] = dut_out;
                ones_d = ones_q + (N_IN+1)'(dut_out);
                if ((dut_out != GOLDEN[idx_q]) && !mv_q) begin
                    mv_d = 1'b1;
                    mi_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    pass_d  = !mv_d;
                end else begin
                    state_d  = ST_DRIVE;
                    idx_d    = idx_q + N_IN'(1);
                    cnt_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            ones_q  <= '0;
            pass_q  <= 1'b0;
            mv_q    <= 1'b0;
            mi_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            ones_q  <= ones_d;
            pass_q  <= pass_d;
            mv_q    <= mv_d;
            mi_q    <= mi_d;
        end
    end

    // The index register doubles as the driven vector, so it holds the last vector when idle.
    assign vec_out    = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign table_out  = table_q;
    assign ones_cnt   = ones_q;
    assign pass       = pass_q;
    assign mism_valid = mv_q;
    assign mism_idx   = mi_q;

endmodule
